// File: rtl/ibex_ss_bus_pkg.sv
// rtl/ibex_ss_bus_pkg.sv - shared types and helpers for the simple-system bus arbiter
package ibex_ss_bus_pkg;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } bus_rsp_t;

    // Width of an index into n items, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ibex_ss_id_fifo.sv
// rtl/ibex_ss_id_fifo.sv - in-order host-ID queue; push and pop together are legal when full
module ibex_ss_id_fifo
    import ibex_ss_bus_pkg::*;
#(
    parameter int Depth = 2,
    parameter int Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PtrW = clog2_min1(Depth);
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_q, rd_q;
    logic [CntW-1:0]  cnt_q, cnt_d;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (push_i && !pop_i) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop_i && !push_i) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= ptr_inc(wr_q);
            if (pop_i)  rd_q <= ptr_inc(rd_q);
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ibex_simple_system_bus_arb.sv
// rtl/ibex_simple_system_bus_arb.sv - round-robin arbiter sharing one peripheral port among NHosts
// Optional response timeout enabled by defining IBEX_SS_ARB_TIMEOUT_EN.
module ibex_simple_system_bus_arb
    import ibex_ss_bus_pkg::*;
#(
    parameter int NHosts         = 2,
    parameter int MaxOutstanding = 2,
    parameter int TimeoutCycles  = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NHosts-1:0]    host_req_i,
    input  logic [NHosts-1:0]    host_we_i,
    input  logic [NHosts*4-1:0]  host_be_i,
    input  logic [NHosts*32-1:0] host_addr_i,
    input  logic [NHosts*32-1:0] host_wdata_i,
    output logic [NHosts-1:0]    host_gnt_o,
    output logic [NHosts-1:0]    host_rvalid_o,
    output logic [NHosts*32-1:0] host_rdata_o,
    output logic [NHosts-1:0]    host_err_o,
    output logic                 dev_req_o,
    output logic                 dev_we_o,
    output logic [3:0]           dev_be_o,
    output logic [31:0]          dev_addr_o,
    output logic [31:0]          dev_wdata_o,
    input  logic                 dev_rvalid_i,
    input  logic [31:0]          dev_rdata_i,
    input  logic                 dev_err_i,
    output logic                 spurious_o
);
    localparam int IdW  = clog2_min1(NHosts);
    localparam int TmoW = clog2_min1(TimeoutCycles);

    logic [IdW-1:0] rr_q, rr_d, win, head;
    logic           found, full, empty, issue, pop, pop_rsp, tmo_fire, spurious_q;
    bus_req_t       sel_req;
    bus_rsp_t       rsp;

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NHosts; i++) begin
            if (!found && host_req_i[(int'(rr_q) + i) % NHosts]) begin
                found = 1'b1;
                win   = IdW'((int'(rr_q) + i) % NHosts);
            end
        end
    end

    // A response or timeout popping this cycle frees the slot the new request needs.
    assign pop_rsp = dev_rvalid_i && !empty && !rst_i;
    assign pop     = pop_rsp || tmo_fire;
    assign issue   = found && (!full || pop) && !rst_i;
    assign rr_d    = issue ? ((int'(win) == NHosts - 1) ? '0 : win + 1'b1) : rr_q;

    always_comb begin
        sel_req = '0;
        if (issue) begin
            sel_req.we    = host_we_i[win];
            sel_req.be    = host_be_i[int'(win)*4 +: 4];
            sel_req.addr  = host_addr_i[int'(win)*32 +: 32];
            sel_req.wdata = host_wdata_i[int'(win)*32 +: 32];
        end
    end

    assign dev_req_o   = issue;
    assign dev_we_o    = sel_req.we;
    assign dev_be_o    = sel_req.be;
    assign dev_addr_o  = sel_req.addr;
    assign dev_wdata_o = sel_req.wdata;

    // A timed-out transaction answers with err set and zero data.
    assign rsp.rdata = pop_rsp ? dev_rdata_i : '0;
    assign rsp.err   = pop_rsp ? dev_err_i : tmo_fire;

    always_comb begin
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        host_rdata_o  = '0;
        host_err_o    = '0;
        for (int h = 0; h < NHosts; h++) begin
            host_gnt_o[h] = issue && (win == IdW'(h));
            if (pop && (head == IdW'(h))) begin
                host_rvalid_o[h]        = 1'b1;
                host_rdata_o[h*32 +: 32] = rsp.rdata;
                host_err_o[h]           = rsp.err;
            end
        end
    end

    ibex_ss_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (issue),
        .pop_i   (pop),
        .data_i  (win),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

`ifdef IBEX_SS_ARB_TIMEOUT_EN
    logic [TmoW-1:0] tmo_q;

    assign tmo_fire = !empty && !dev_rvalid_i && !rst_i && (tmo_q == TmoW'(TimeoutCycles - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || empty || pop) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + 1'b1;
        end
    end
`else
    logic [TmoW-1:0] tmo_unused;
    assign tmo_unused = '0;
    assign tmo_fire   = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            spurious_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
            if (dev_rvalid_i && empty) begin
                spurious_q <= 1'b1;
            end
        end
    end

    assign spurious_o = spurious_q;

endmodule

// File: tb/tb_ibex_simple_system_bus_arb.sv
// tb/tb_ibex_simple_system_bus_arb.sv - directed self-checking bench for the bus arbiter
module tb_ibex_simple_system_bus_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  host_req, host_we, host_gnt, host_rvalid, host_err;
    logic [7:0]  host_be;
    logic [63:0] host_addr, host_wdata, host_rdata;
    logic        dev_req, dev_we, dev_rvalid, dev_err, spurious;
    logic [3:0]  dev_be;
    logic [31:0] dev_addr, dev_wdata, dev_rdata;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    ibex_simple_system_bus_arb #(
        .NHosts(2), .MaxOutstanding(2), .TimeoutCycles(4)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .host_req_i(host_req), .host_we_i(host_we), .host_be_i(host_be),
        .host_addr_i(host_addr), .host_wdata_i(host_wdata),
        .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid),
        .host_rdata_o(host_rdata), .host_err_o(host_err),
        .dev_req_o(dev_req), .dev_we_o(dev_we), .dev_be_o(dev_be),
        .dev_addr_o(dev_addr), .dev_wdata_o(dev_wdata),
        .dev_rvalid_i(dev_rvalid), .dev_rdata_i(dev_rdata), .dev_err_i(dev_err),
        .spurious_o(spurious)
    );

    task automatic clear_inputs();
        host_req = '0; host_we = '0; host_be = '0; host_addr = '0; host_wdata = '0;
        dev_rvalid = 1'b0; dev_rdata = '0; dev_err = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_vec++; if (dev_req !== 1'b0) begin n_err++; $display("FAIL reset_dev_req got %b exp 0", dev_req); end
        n_vec++; if (host_gnt !== 2'b00) begin n_err++; $display("FAIL reset_gnt got %b exp 00", host_gnt); end
        n_vec++; if (host_rvalid !== 2'b00 || host_err !== 2'b00) begin n_err++; $display("FAIL reset_rsp got %b/%b exp 00/00", host_rvalid, host_err); end
        n_vec++; if (spurious !== 1'b0) begin n_err++; $display("FAIL reset_spurious got %b exp 0", spurious); end
    endtask

    task automatic test_single();
        apply_reset();
        host_req = 2'b01; host_we = 2'b01; host_be = 8'h0F; host_addr = 64'h0; host_wdata = 64'h1;
        #1;
        n_vec++; if (host_gnt !== 2'b01) begin n_err++; $display("FAIL single_gnt got %b exp 01", host_gnt); end
        n_vec++; if ({dev_req, dev_we, dev_be, dev_addr, dev_wdata} !== {1'b1, 1'b1, 4'hF, 32'h0, 32'h1})
            begin n_err++; $display("FAIL single_dev got %b %b %h %h %h exp 1 1 f 0 1", dev_req, dev_we, dev_be, dev_addr, dev_wdata); end
        @(negedge clk);
        clear_inputs();
        dev_rvalid = 1'b1; dev_rdata = 32'hCAFE_F00D;
        #1;
        n_vec++; if (host_rvalid !== 2'b01) begin n_err++; $display("FAIL single_rvalid got %b exp 01", host_rvalid); end
        n_vec++; if (host_rdata !== 64'h0000_0000_CAFE_F00D) begin n_err++; $display("FAIL single_rdata got %h exp 00000000cafef00d", host_rdata); end
        n_vec++; if (dev_req !== 1'b0) begin n_err++; $display("FAIL single_idle got %b exp 0", dev_req); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_contention();
        logic [1:0]  exp_g, prev_g;
        logic [31:0] exp_a;
        apply_reset();
        prev_g = 2'b00;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            host_req = (i < 6) ? 2'b11 : 2'b00;
            host_addr = {32'h2000, 32'h1000};
            dev_rvalid = (i > 0); dev_rdata = 32'h100 + i;
            #1;
            exp_g = (i == 6) ? 2'b00 : ((i % 2 == 0) ? 2'b01 : 2'b10);
            exp_a = (i == 6) ? 32'h0 : ((i % 2 == 0) ? 32'h1000 : 32'h2000);
            n_vec++; if (host_gnt !== exp_g) begin n_err++; $display("FAIL cont_gnt[%0d] got %b exp %b", i, host_gnt, exp_g); end
            n_vec++; if (dev_addr !== exp_a) begin n_err++; $display("FAIL cont_addr[%0d] got %h exp %h", i, dev_addr, exp_a); end
            if (i > 0) begin
                n_vec++; if (host_rvalid !== prev_g) begin n_err++; $display("FAIL cont_rvalid[%0d] got %b exp %b", i, host_rvalid, prev_g); end
                n_vec++; if (host_rdata[((i - 1) % 2)*32 +: 32] !== 32'h100 + i)
                    begin n_err++; $display("FAIL cont_rdata[%0d] got %h exp %h", i, host_rdata[((i - 1) % 2)*32 +: 32], 32'h100 + i); end
            end
            prev_g = exp_g;
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        // per cycle: host_req, dev_rvalid, expected gnt, expected host rvalid
        logic [1:0] req_v [6] = '{2'b11, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00};
        logic       rv_v  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [1:0] gnt_v [6] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
        logic [1:0] rsp_v [6] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            host_req = req_v[i]; dev_rvalid = rv_v[i]; dev_rdata = 32'hA0 + i;
            #1;
            n_vec++; if (host_gnt !== gnt_v[i] || dev_req !== (gnt_v[i] != 2'b00))
                begin n_err++; $display("FAIL bp_gnt[%0d] got %b req %b exp %b", i, host_gnt, dev_req, gnt_v[i]); end
            n_vec++; if (host_rvalid !== rsp_v[i]) begin n_err++; $display("FAIL bp_rvalid[%0d] got %b exp %b", i, host_rvalid, rsp_v[i]); end
        end
        n_vec++; if (spurious !== 1'b0) begin n_err++; $display("FAIL bp_spurious got %b exp 0", spurious); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_spurious();
        apply_reset();
        dev_rvalid = 1'b1; dev_rdata = 32'hDEAD;
        #1;
        n_vec++; if (host_rvalid !== 2'b00) begin n_err++; $display("FAIL spur_rvalid got %b exp 00", host_rvalid); end
        @(negedge clk);
        clear_inputs();
        n_vec++; if (spurious !== 1'b1) begin n_err++; $display("FAIL spur_set got %b exp 1", spurious); end
        repeat (3) @(negedge clk);
        n_vec++; if (spurious !== 1'b1) begin n_err++; $display("FAIL spur_sticky got %b exp 1", spurious); end
        apply_reset();
        n_vec++; if (spurious !== 1'b0) begin n_err++; $display("FAIL spur_clear got %b exp 0", spurious); end
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        host_req = 2'b11;
        #1;
        n_vec++; if (host_gnt !== 2'b01) begin n_err++; $display("FAIL mid_gnt0 got %b exp 01", host_gnt); end
        @(negedge clk);
        #1;
        n_vec++; if (host_gnt !== 2'b10) begin n_err++; $display("FAIL mid_gnt1 got %b exp 10", host_gnt); end
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dev_rvalid = 1'b1;
        #1;
        n_vec++; if (host_rvalid !== 2'b00) begin n_err++; $display("FAIL mid_rvalid got %b exp 00", host_rvalid); end
        @(negedge clk);
        dev_rvalid = 1'b0; host_req = 2'b11;
        #1;
        n_vec++; if (spurious !== 1'b1) begin n_err++; $display("FAIL mid_spurious got %b exp 1", spurious); end
        n_vec++; if (host_gnt !== 2'b01) begin n_err++; $display("FAIL mid_regnt got %b exp 01", host_gnt); end
        @(negedge clk);
        clear_inputs();
    endtask

`ifdef IBEX_SS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        host_req = 2'b10; dev_rdata = 32'h5555_AAAA;
        #1;
        n_vec++; if (host_gnt !== 2'b10) begin n_err++; $display("FAIL tmo_gnt got %b exp 10", host_gnt); end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            host_req = 2'b00;
            #1;
            if (c < 4) begin
                n_vec++; if (host_rvalid !== 2'b00) begin n_err++; $display("FAIL tmo_early[%0d] got %b exp 00", c, host_rvalid); end
            end else begin
                n_vec++; if (host_rvalid !== 2'b10 || host_err !== 2'b10)
                    begin n_err++; $display("FAIL tmo_fire got %b/%b exp 10/10", host_rvalid, host_err); end
                n_vec++; if (host_rdata !== 64'h0) begin n_err++; $display("FAIL tmo_rdata got %h exp 0", host_rdata); end
            end
        end
        @(negedge clk);
        clear_inputs();
    endtask
`endif

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_spurious();
        test_reset_midflight();
`ifdef IBEX_SS_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
